// File: rtl/nh_lcd_pkg.sv
// Shared types and constants for the LCD parallel bus engine.
// State encoding, direction codes and debug-word field offsets.
package nh_lcd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_SETUP    = 4'd2,
        ST_STROBE   = 4'd3,
        ST_HOLD     = 4'd4,
        ST_FINISHED = 4'd5
    } lcd_state_e;

    localparam logic DIR_WRITE = 1'b0;
    localparam logic DIR_READ  = 1'b1;

    localparam int DBG_STATE_LSB = 0;
    localparam int DBG_STATE_W   = 4;
    localparam int DBG_DIR_BIT   = 4;
    localparam int DBG_CNT_LSB   = 16;
    localparam int DBG_CNT_W     = 16;

    localparam int PHASE_W = 8;

endpackage

// File: rtl/nh_lcd_phase_timer.sv
// Down-counter for one bus phase: load a length, flag its last cycle.
// A length of 0 or 1 both give a single-cycle phase.
module nh_lcd_phase_timer
    import nh_lcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [PHASE_W-1:0] i_len,
    output logic               o_last
);

    logic [PHASE_W-1:0] cnt_q;
    logic [PHASE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = (i_len == '0) ? '0 : i_len - PHASE_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PHASE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_last = (cnt_q == '0);

endmodule

// File: rtl/nh_lcd_bus_engine.sv
// Burst engine driving an 8080-style LCD bus with setup/strobe/hold phases.
// Read bursts are built only when NH_LCD_READ_EN is defined.
module nh_lcd_bus_engine
    import nh_lcd_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    input  logic                   i_write_stb,
    input  logic                   i_read_stb,
    input  logic                   i_cmd_parameter,
    input  logic [COUNT_WIDTH-1:0] i_count,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    output logic                   o_rd_valid,
    output logic                   o_busy,
    output logic                   o_finished,
    output logic                   o_cmd_mode,
    output logic                   o_write,
    output logic                   o_read,
    output logic                   o_data_out_en,
    output logic [DATA_WIDTH-1:0]  o_data_out,
    input  logic [DATA_WIDTH-1:0]  i_data_in,
    output logic [31:0]            o_debug
);

    localparam logic [PHASE_W-1:0] SETUP_LEN  = PHASE_W'(SETUP_CYCLES);
    localparam logic [PHASE_W-1:0] STROBE_LEN = PHASE_W'(STROBE_CYCLES);
    localparam logic [PHASE_W-1:0] HOLD_LEN   = PHASE_W'(HOLD_CYCLES);

    lcd_state_e             state_q;
    lcd_state_e             state_d;
    logic                   dir_q;
    logic                   dir_d;
    logic                   cmd_q;
    logic                   cmd_d;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic [COUNT_WIDTH-1:0] remaining_d;
    logic [DATA_WIDTH-1:0]  data_out_q;
    logic [DATA_WIDTH-1:0]  data_out_d;
    logic                   read_req;
    logic                   wr_fire;
    logic                   in_phase;
    logic                   timer_load;
    logic [PHASE_W-1:0]     timer_len;
    logic                   phase_last;

`ifdef NH_LCD_READ_EN
    assign read_req = i_read_stb;
`else
    assign read_req = 1'b0;
`endif

    nh_lcd_phase_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (timer_load),
        .i_len  (timer_len),
        .o_last (phase_last)
    );

    assign o_wr_ready = (state_q == ST_FETCH) && (dir_q == DIR_WRITE)
                        && i_enable;
    assign wr_fire    = o_wr_ready && i_wr_valid;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cmd_d       = cmd_q;
        remaining_d = remaining_q;
        data_out_d  = data_out_q;
        timer_load  = 1'b0;
        timer_len   = SETUP_LEN;
        unique case (state_q)
            ST_IDLE: begin
                if (i_enable && (i_write_stb || read_req)) begin
                    dir_d       = i_write_stb ? DIR_WRITE : DIR_READ;
                    cmd_d       = i_cmd_parameter;
                    remaining_d = i_count;
                    state_d     = (i_count == '0) ? ST_FINISHED : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!i_enable) begin
                    state_d = ST_FINISHED;
                end else if (dir_q == DIR_READ || wr_fire) begin
                    if (wr_fire) begin
                        data_out_d = i_wr_data;
                    end
                    state_d    = ST_SETUP;
                    timer_load = 1'b1;
                    timer_len  = SETUP_LEN;
                end
            end
            ST_SETUP: begin
                if (phase_last) begin
                    state_d    = ST_STROBE;
                    timer_load = 1'b1;
                    timer_len  = STROBE_LEN;
                end
            end
            ST_STROBE: begin
                if (phase_last) begin
                    state_d    = ST_HOLD;
                    timer_load = 1'b1;
                    timer_len  = HOLD_LEN;
                end
            end
            ST_HOLD: begin
                // Dropping i_enable lets this transfer finish but starts no more.
                if (phase_last) begin
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    if (remaining_d != '0 && i_enable) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_FINISHED;
                    end
                end
            end
            ST_FINISHED: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_WRITE;
            cmd_q       <= 1'b0;
            remaining_q <= '0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cmd_q       <= cmd_d;
            remaining_q <= remaining_d;
            data_out_q  <= data_out_d;
        end
    end

    assign in_phase = (state_q == ST_SETUP) || (state_q == ST_STROBE)
                      || (state_q == ST_HOLD);

    assign o_busy        = (state_q != ST_IDLE);
    assign o_finished    = (state_q == ST_FINISHED);
    assign o_data_out_en = in_phase && (dir_q == DIR_WRITE);
    assign o_write       = (state_q == ST_STROBE) && (dir_q == DIR_WRITE);
    assign o_data_out    = data_out_q;

    // Gated by rst_n so the pass-through in IDLE also reads 0 under reset.
    assign o_cmd_mode = rst_n
                        && ((state_q == ST_IDLE) ? i_cmd_parameter : cmd_q);

`ifdef NH_LCD_READ_EN
    logic                  rd_capture;
    logic                  rd_valid_q;
    logic                  rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    assign rd_capture = (state_q == ST_STROBE) && (dir_q == DIR_READ)
                        && phase_last;

    always_comb begin
        rd_valid_d = rd_capture;
        rd_data_d  = rd_capture ? i_data_in : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign o_read     = (state_q == ST_STROBE) && (dir_q == DIR_READ);
    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_data_q;
`else
    logic unused_read;
    assign unused_read = ^{i_read_stb, i_data_in};

    assign o_read     = 1'b0;
    assign o_rd_valid = 1'b0;
    assign o_rd_data  = '0;
`endif

    always_comb begin
        o_debug = '0;
        o_debug[DBG_STATE_LSB +: DBG_STATE_W] = state_q;
        o_debug[DBG_DIR_BIT] = dir_q;
        o_debug[DBG_CNT_LSB +: DBG_CNT_W] = DBG_CNT_W'(remaining_q);
    end

endmodule

// File: tb/tb_nh_lcd_bus_engine.sv
// Directed testbench for nh_lcd_bus_engine.
// Read checks are compiled only when NH_LCD_READ_EN is defined.
module tb_nh_lcd_bus_engine;
    import nh_lcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic        i_write_stb;
    logic        i_read_stb;
    logic        i_cmd_parameter;
    logic [15:0] i_count;
    logic [7:0]  i_wr_data;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [7:0]  o_rd_data;
    logic        o_rd_valid;
    logic        o_busy;
    logic        o_finished;
    logic        o_cmd_mode;
    logic        o_write;
    logic        o_read;
    logic        o_data_out_en;
    logic [7:0]  o_data_out;
    logic [7:0]  i_data_in;
    logic [31:0] o_debug;

    nh_lcd_bus_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_enable        (i_enable),
        .i_write_stb     (i_write_stb),
        .i_read_stb      (i_read_stb),
        .i_cmd_parameter (i_cmd_parameter),
        .i_count         (i_count),
        .i_wr_data       (i_wr_data),
        .i_wr_valid      (i_wr_valid),
        .o_wr_ready      (o_wr_ready),
        .o_rd_data       (o_rd_data),
        .o_rd_valid      (o_rd_valid),
        .o_busy          (o_busy),
        .o_finished      (o_finished),
        .o_cmd_mode      (o_cmd_mode),
        .o_write         (o_write),
        .o_read          (o_read),
        .o_data_out_en   (o_data_out_en),
        .o_data_out      (o_data_out),
        .i_data_in       (i_data_in),
        .o_debug         (o_debug)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wdata [8];
    logic [7:0]  rd_src [2];
    int          widx;
    int          stall_left;
    int          stall_ready;
    int          stall_writes;
    int          abort_at;
    logic        exp_cmd;
    int          n_write;
    int          n_fin;
    int          n_rdv;
    int          n_read_cyc;
    int          en_cyc;
    int          busy_cyc;
    int          fin_cyc;
    int          cmd_bad;
    int          widths [8];
    logic [7:0]  wvals [8];
    logic [7:0]  rvals [8];
    logic [31:0] first_dbg;
    bit          got_dbg;

    task automatic start(input logic w, input logic r,
                         input int cnt, input logic cmd);
        @(negedge clk);
        widx            = 0;
        i_wr_data       = wdata[0];
        i_wr_valid      = 1'b1;
        i_write_stb     = w;
        i_read_stb      = r;
        i_count         = 16'(cnt);
        i_cmd_parameter = cmd;
        exp_cmd         = cmd;
    endtask

    task automatic run_burst(input int budget);
        int  run;
        int  tail;
        bit  hs;
        bit  fin_seen;
        run = 0; tail = 0; hs = 0; fin_seen = 0;
        n_write = 0; n_fin = 0; n_rdv = 0; n_read_cyc = 0;
        en_cyc = 0; busy_cyc = 0; fin_cyc = -1; cmd_bad = 0;
        stall_ready = 0; stall_writes = 0;
        got_dbg = 0; first_dbg = '0;
        for (int k = 0; k < 8; k++) widths[k] = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            i_write_stb     = 1'b0;
            i_read_stb      = 1'b0;
            i_cmd_parameter = !exp_cmd;
            if (hs && widx < 7) widx++;
            i_wr_data = wdata[widx];
            if (o_busy && !got_dbg) begin
                first_dbg = o_debug;
                got_dbg   = 1;
            end
            if (o_busy) busy_cyc++;
            if (o_data_out_en) en_cyc++;
            if (o_read) n_read_cyc++;
            if (o_busy && o_cmd_mode !== exp_cmd) cmd_bad++;
            if (o_rd_valid === 1'b1) begin
                if (n_rdv < 8) rvals[n_rdv] = o_rd_data;
                n_rdv++;
            end
            i_data_in = (n_rdv > 0) ? rd_src[1] : rd_src[0];
            if (o_write === 1'b1) begin
                if (run == 0) begin
                    if (n_write < 8) wvals[n_write] = o_data_out;
                    n_write++;
                    if (n_write == abort_at) i_enable = 1'b0;
                end
                run++;
            end else if (run > 0) begin
                if (n_write <= 8) widths[n_write-1] = run;
                run = 0;
            end
            if (o_finished === 1'b1) begin
                if (!fin_seen) fin_cyc = cyc;
                n_fin++;
                fin_seen = 1;
            end
            if (got_dbg && stall_left > 0) begin
                i_wr_valid = 1'b0;
                stall_left--;
                if (o_wr_ready === 1'b1) stall_ready++;
                if (o_write === 1'b1) stall_writes++;
            end else begin
                i_wr_valid = 1'b1;
            end
            hs = o_wr_ready && i_wr_valid;
            if (fin_seen) begin
                tail++;
                if (tail > 2) break;
            end
        end
        i_enable = 1'b1;
        abort_at = 0;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        i_enable        = 1'b1;
        i_write_stb     = 1'b1;
        i_read_stb      = 1'b0;
        i_cmd_parameter = 1'b1;
        i_count         = 16'd3;
        i_wr_data       = 8'h00;
        i_wr_valid      = 1'b1;
        i_data_in       = 8'h00;
        #12;
        checks++;
        if (o_busy !== 1'b0 || o_finished !== 1'b0 || o_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: busy=%b fin=%b rdy=%b want 0", o_busy,
                     o_finished, o_wr_ready);
        end
        checks++;
        if (o_cmd_mode !== 1'b0 || o_write !== 1'b0 || o_data_out_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: cmd=%b wr=%b en=%b want 0", o_cmd_mode,
                     o_write, o_data_out_en);
        end
        checks++;
        if (o_debug !== 32'h0 || o_data_out !== 8'h0 || o_rd_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_data: dbg=%h do=%h rd=%h want 0", o_debug,
                     o_data_out, o_rd_data);
        end
        @(negedge clk);
        i_write_stb     = 1'b0;
        i_cmd_parameter = 1'b0;
        rst_n           = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_burst();
        logic [7:0] exp [3];
        exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
        wdata[0] = 8'hA1; wdata[1] = 8'hB2; wdata[2] = 8'hC3;
        wdata[3] = 8'hEE;
        start(1'b1, 1'b0, 3, 1'b1);
        run_burst(80);
        checks++;
        if (n_write !== 3) begin
            errors++;
            $display("FAIL wr_pulses: got %0d want 3", n_write);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (wvals[k] !== exp[k] || widths[k] !== 2) begin
                errors++;
                $display("FAIL wr_xfer%0d: data=%h width=%0d want %h/2", k,
                         wvals[k], widths[k], exp[k]);
            end
        end
        checks++;
        if (en_cyc !== 12) begin
            errors++;
            $display("FAIL wr_en_cycles: got %0d want 12", en_cyc);
        end
        checks++;
        if (n_fin !== 1 || busy_cyc !== 16) begin
            errors++;
            $display("FAIL wr_finish: fin=%0d busy=%0d want 1/16", n_fin, busy_cyc);
        end
        checks++;
        if (first_dbg !== {16'd3, 11'd0, DIR_WRITE, 4'd1}) begin
            errors++;
            $display("FAIL wr_debug: got %h want %h", first_dbg,
                     {16'd3, 11'd0, DIR_WRITE, 4'd1});
        end
        checks++;
        if (cmd_bad !== 0) begin
            errors++;
            $display("FAIL wr_cmd_mode: %0d bad cycles want 0", cmd_bad);
        end
    endtask

    task automatic test_backpressure();
        wdata[0] = 8'h77; wdata[1] = 8'h00;
        stall_left = 5;
        start(1'b1, 1'b0, 1, 1'b0);
        run_burst(60);
        checks++;
        if (stall_ready !== 5 || stall_writes !== 0) begin
            errors++;
            $display("FAIL bp_stall: ready=%0d writes=%0d want 5/0",
                     stall_ready, stall_writes);
        end
        checks++;
        if (n_write !== 1 || wvals[0] !== 8'h77) begin
            errors++;
            $display("FAIL bp_write: n=%0d data=%h want 1/77", n_write, wvals[0]);
        end
        checks++;
        if (busy_cyc !== 11 || n_fin !== 1) begin
            errors++;
            $display("FAIL bp_busy: busy=%0d fin=%0d want 11/1", busy_cyc, n_fin);
        end
    endtask

    task automatic test_simultaneous();
        wdata[0] = 8'h3D; wdata[1] = 8'h00;
        start(1'b1, 1'b1, 1, 1'b0);
        run_burst(60);
        checks++;
        if (n_write !== 1 || n_read_cyc !== 0) begin
            errors++;
            $display("FAIL sim_dir: writes=%0d reads=%0d want 1/0", n_write,
                     n_read_cyc);
        end
        checks++;
        if (first_dbg[4] !== DIR_WRITE || wvals[0] !== 8'h3D) begin
            errors++;
            $display("FAIL sim_write: dir=%b data=%h want %b/3d", first_dbg[4],
                     wvals[0], DIR_WRITE);
        end
    endtask

    task automatic test_zero_count();
        wdata[0] = 8'h11;
        start(1'b1, 1'b0, 0, 1'b0);
        run_burst(20);
        checks++;
        if (n_fin !== 1 || fin_cyc < 0 || fin_cyc > 1) begin
            errors++;
            $display("FAIL zero_finish: fin=%0d at=%0d want 1 at<=1", n_fin,
                     fin_cyc);
        end
        checks++;
        if (n_write !== 0 || en_cyc !== 0) begin
            errors++;
            $display("FAIL zero_bus: writes=%0d en=%0d want 0/0", n_write, en_cyc);
        end
    endtask

    task automatic test_abort();
        wdata[0] = 8'h01; wdata[1] = 8'h02; wdata[2] = 8'h03;
        wdata[3] = 8'h04;
        abort_at = 2;
        start(1'b1, 1'b0, 4, 1'b1);
        run_burst(80);
        checks++;
        if (n_write !== 2) begin
            errors++;
            $display("FAIL abort_pulses: got %0d want 2", n_write);
        end
        checks++;
        if (n_fin !== 1 || en_cyc !== 8) begin
            errors++;
            $display("FAIL abort_end: fin=%0d en=%0d want 1/8", n_fin, en_cyc);
        end
        checks++;
        if (wvals[1] !== 8'h02 || widths[1] !== 2) begin
            errors++;
            $display("FAIL abort_xfer: data=%h width=%0d want 02/2", wvals[1],
                     widths[1]);
        end
    endtask

    task automatic test_reset_mid_strobe();
        bit seen;
        seen = 0;
        wdata[0] = 8'h9C; wdata[1] = 8'h9D;
        start(1'b1, 1'b0, 2, 1'b1);
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            i_write_stb = 1'b0;
            if (o_write === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_wait: o_write got 0 want 1 within 20 cycles");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_finished, o_wr_ready, o_cmd_mode, o_write, o_read,
             o_data_out_en, o_rd_valid} !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_ctl: got %b want 00000000",
                     {o_busy, o_finished, o_wr_ready, o_cmd_mode, o_write,
                      o_read, o_data_out_en, o_rd_valid});
        end
        checks++;
        if (o_data_out !== 8'h00 || o_debug !== 32'h0 || o_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_data: do=%h dbg=%h rd=%h want 0", o_data_out,
                     o_debug, o_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef NH_LCD_READ_EN
    task automatic test_read_burst();
        rd_src[0] = 8'h5A; rd_src[1] = 8'h3C;
        start(1'b0, 1'b1, 2, 1'b0);
        i_data_in = 8'h5A;
        run_burst(60);
        checks++;
        if (n_rdv !== 2) begin
            errors++;
            $display("FAIL rd_count: got %0d want 2", n_rdv);
        end
        checks++;
        if (rvals[0] !== 8'h5A || rvals[1] !== 8'h3C) begin
            errors++;
            $display("FAIL rd_data: got %h %h want 5a 3c", rvals[0], rvals[1]);
        end
        checks++;
        if (en_cyc !== 0 || n_write !== 0 || n_fin !== 1) begin
            errors++;
            $display("FAIL rd_bus: en=%0d wr=%0d fin=%0d want 0/0/1", en_cyc,
                     n_write, n_fin);
        end
    endtask
`else
    task automatic test_read_disabled();
        int busy_seen;
        int rd_seen;
        busy_seen = 0;
        rd_seen   = 0;
        @(negedge clk);
        i_read_stb = 1'b1;
        i_count    = 16'd3;
        i_data_in  = 8'hFF;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (o_busy !== 1'b0) busy_seen++;
            if (o_read !== 1'b0 || o_rd_valid !== 1'b0 || o_rd_data !== 8'h00)
                rd_seen++;
        end
        i_read_stb = 1'b0;
        checks++;
        if (busy_seen !== 0) begin
            errors++;
            $display("FAIL nord_busy: busy cycles %0d want 0", busy_seen);
        end
        checks++;
        if (rd_seen !== 0) begin
            errors++;
            $display("FAIL nord_outputs: active cycles %0d want 0", rd_seen);
        end
    endtask
`endif

    initial begin
        stall_left = 0;
        abort_at   = 0;
        exp_cmd    = 1'b0;
        widx       = 0;
        rd_src[0]  = 8'h00;
        rd_src[1]  = 8'h00;
        for (int k = 0; k < 8; k++) wdata[k] = 8'h00;
        test_reset();
        test_write_burst();
        test_backpressure();
        test_simultaneous();
        test_zero_count();
        test_abort();
        test_reset_mid_strobe();
`ifdef NH_LCD_READ_EN
        test_read_burst();
`else
        test_read_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
